plot_job_sequencer: RTL

Sequences a full raster plot job for the two-axis stepper plotter. It walks a pixel buffer row by row, reading one intensity byte per pixel and thresholding it. For each pixel it issues one motion command (pixel glyph or empty advance) to the plotter motion engine over a valid/ready/done handshake. At row ends it issues carriage-return and line-shift commands. It sits between the image frame buffer (BRAM read port) and the stepper motion engine, replacing the switch-driven next-state selection.

---
 rtl/plotter_pkg.sv | 24 ++
 rtl/plot_job_sequencer_if.sv | 28 ++
 rtl/raster_addr_gen.sv | 56 +++++
 rtl/plot_job_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/plotter_pkg.sv
// Shared types and constants for the stepper plotter job path.
// Pixel grid dimensions derive from the mechanical step limits.
package plotter_pkg;

  localparam int unsigned STEPS_PER_PIXEL = 9;
  localparam int unsigned H_STEPS_MAX     = 720;
  localparam int unsigned V_STEPS_MAX     = 960;
  localparam int unsigned PLOT_H_PIXELS   = H_STEPS_MAX / STEPS_PER_PIXEL;
  localparam int unsigned PLOT_V_PIXELS   = V_STEPS_MAX / STEPS_PER_PIXEL;
  localparam int unsigned COORD_W         = 7;

  typedef enum logic [1:0] {
    CMD_EMPTY  = 2'd0,
    CMD_PIXEL  = 2'd1,
    CMD_RETURN = 2'd2,
    CMD_SHIFT  = 2'd3
  } cmd_op_e;

  // Intensity at or above the threshold is drawn.
  function automatic cmd_op_e pixel_op(input int unsigned data, input int unsigned thr);
    return (data >= thr) ? CMD_PIXEL : CMD_EMPTY;
  endfunction

endpackage

// File: rtl/plot_job_sequencer_if.sv
// Frame-buffer read port and motion-engine command handshake.
// master = sequencer side, slave = memory/engine side.
interface plot_job_sequencer_if
  import plotter_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              cmd_valid;
  cmd_op_e           cmd_op;
  logic              cmd_ready;
  logic              cmd_done;

  modport master (
    output mem_rd, mem_addr, cmd_valid, cmd_op,
    input  mem_data, cmd_ready, cmd_done
  );

  modport slave (
    input  mem_rd, mem_addr, cmd_valid, cmd_op,
    output mem_data, cmd_ready, cmd_done
  );

endinterface

// File: rtl/raster_addr_gen.sv
// Column/row counters and a running row base so the buffer address
// never needs a multiplier.
module raster_addr_gen #(
  parameter int unsigned H_PIXELS = 80,
  parameter int unsigned V_PIXELS = 106,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned COORD_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_adv_col,
  input  logic               i_next_row,
  output logic [COORD_W-1:0] o_col,
  output logic [COORD_W-1:0] o_row,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_last_col_c,
  output logic               o_last_row_c
);

  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(H_PIXELS);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(H_PIXELS - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(V_PIXELS - 1);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [ADDR_W-1:0]  r_row_base;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_next_base;

  assign w_next_base = r_row_base + ROW_STEP;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_next_row) begin
      r_col      <= '0;
      r_row      <= r_row + COORD_W'(1);
      r_row_base <= w_next_base;
      r_addr     <= w_next_base;
    end else if (i_adv_col) begin
      r_col  <= r_col + COORD_W'(1);
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_addr       = r_addr;
  assign o_last_col_c = (r_col == LAST_COL);
  assign o_last_row_c = (r_row == LAST_ROW);

endmodule

// File: rtl/plot_job_sequencer.sv
// Raster job sequencer: fetches and thresholds each pixel, then issues one
// motion command per pixel plus carriage-return/line-shift at row ends.
module plot_job_sequencer
  import plotter_pkg::*;
#(
  parameter int unsigned H_PIXELS    = PLOT_H_PIXELS,
  parameter int unsigned V_PIXELS    = PLOT_V_PIXELS,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic                clk_100mhz,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic [DATA_W-1:0]   threshold,
  plot_job_sequencer_if.master bus,
  output logic                busy,
  output logic                drawing_done,
  output logic [COORD_W-1:0]  cur_col,
  output logic [COORD_W-1:0]  cur_row
);

  localparam int unsigned LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_DATA, S_ISSUE, S_WAIT_DONE, S_DONE
  } state_e;

  state_e              r_state;
  logic                r_mem_rd;
  logic                r_cmd_valid;
  cmd_op_e             r_cmd_op;
  logic                r_busy;
  logic                r_drawing_done;
  logic [DATA_W-1:0]   r_threshold;
  logic [LAT_W-1:0]    r_lat_cnt;

  logic                w_start_ok;
  logic                w_done_evt;
  logic                w_is_pixel;
  logic                w_adv_col;
  logic                w_next_row;
  logic                w_last_col;
  logic                w_last_row;
  logic [ADDR_W-1:0]   w_addr;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_done_evt = (r_state == S_WAIT_DONE) && bus.cmd_done;
  assign w_is_pixel = (r_cmd_op == CMD_EMPTY) || (r_cmd_op == CMD_PIXEL);
  assign w_adv_col  = w_done_evt && w_is_pixel && !w_last_col;
  assign w_next_row = w_done_evt && (r_cmd_op == CMD_SHIFT);

  raster_addr_gen #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS),
    .ADDR_W   (ADDR_W),
    .COORD_W  (COORD_W)
  ) u_addr_gen (
    .clk          (clk_100mhz),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_adv_col    (w_adv_col),
    .i_next_row   (w_next_row),
    .o_col        (cur_col),
    .o_row        (cur_row),
    .o_addr       (w_addr),
    .o_last_col_c (w_last_col),
    .o_last_row_c (w_last_row)
  );

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_mem_rd       <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_cmd_op       <= CMD_EMPTY;
      r_busy         <= 1'b0;
      r_drawing_done <= 1'b0;
      r_threshold    <= '0;
      r_lat_cnt      <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_drawing_done <= 1'b0;
            r_threshold    <= threshold;
            r_busy         <= 1'b1;
            r_state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!pause) begin
            r_mem_rd  <= 1'b1;
            r_lat_cnt <= '0;
            r_state   <= S_WAIT_DATA;
          end
        end
        // Counter reaches MEM_LATENCY on the edge where the read data is valid.
        S_WAIT_DATA: begin
          if (r_lat_cnt == LAT_W'(MEM_LATENCY)) begin
            r_cmd_op    <= pixel_op(32'(bus.mem_data), 32'(r_threshold));
            r_cmd_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        S_ISSUE: begin
          if (bus.cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.cmd_done) begin
            case (r_cmd_op)
              CMD_EMPTY, CMD_PIXEL: begin
                if (w_last_col) begin
                  r_cmd_op    <= CMD_RETURN;
                  r_cmd_valid <= 1'b1;
                  r_state     <= S_ISSUE;
                end else begin
                  r_state <= S_FETCH;
                end
              end
              CMD_RETURN: begin
                if (w_last_row) begin
                  r_busy         <= 1'b0;
                  r_drawing_done <= 1'b1;
                  r_state        <= S_DONE;
                end else begin
                  r_cmd_op    <= CMD_SHIFT;
                  r_cmd_valid <= 1'b1;
                  r_state     <= S_ISSUE;
                end
              end
              default: r_state <= S_FETCH;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = w_addr;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_op    = r_cmd_op;
  assign busy          = r_busy;
  assign drawing_done  = r_drawing_done;

endmodule
